// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared state encoding and default sizes for the shift sequencer
package shift_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_bitcnt.sv
// rtl/shift_seq_bitcnt.sv - bit counter for the shift sequencer, flags the last bit of a word
module shift_seq_bitcnt
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  assign last = (cnt == LAST_VAL);

  // count shift edges; clear wins, and the count wraps to 0 after the last bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - word-to-serial sequencer for a SIPO shift register (option: SHIFT_SEQ_CHECK_EN)
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_d,
  output logic             shift_en,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             accept;
  logic             deliver;
  logic [CNT_W-1:0] bit_idx;

  // a new word is taken in IDLE, or in HOLD on the same edge the old result leaves
  assign in_ready = rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // MSB first: bit index counts down from WIDTH-1 as cnt counts up
  assign bit_idx  = CNT_W'(WIDTH - 1) - cnt;
  assign shift_en = rst && (state == SHIFT);
  assign ser_d    = shift_en && word_q[bit_idx];
  assign busy     = rst && (state != IDLE);

  shift_seq_bitcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (state == SHIFT),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // sequencing FSM: latch word, shift WIDTH bits, capture readback, hold until consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      word_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_q <= in_data;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_last) begin
            state <= CAPT;
          end
        end
        CAPT: begin
          out_data  <= sr_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (deliver) begin
            out_valid <= 1'b0;
            if (accept) begin
              word_q <= in_data;
              state  <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SEQ_CHECK_EN
  // readback check: flag when the captured word differs from the word sent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (state == CAPT) begin
      err <= (sr_q != word_q);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl (WIDTH=4, optional SHIFT_SEQ_CHECK_EN)
module tb_shift_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_d;
  logic         shift_en;
  logic [W-1:0] sr_q;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         err;

  logic         man_ready;
  logic         rnd_ready = 1'b1;
  logic         rand_mode;
  logic [W-1:0] sr = '0;
  logic [W-1:0] force_mask = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rnd_ready : man_ready;
  assign sr_q      = sr | force_mask;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_d     (ser_d),
    .shift_en  (shift_en),
    .sr_q      (sr_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  // SIPO shift register fed by the controller, never reset
  always @(posedge clk) if (shift_en) sr <= {sr[W-2:0], ser_d};

  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level reference model: words accepted must reappear serially and then in order
  logic [W-1:0] acc_q[$];
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           cyc = 0;
  int           nb = 0;
  int           out_cnt = 0;
  logic [W-1:0] sbits = '0;
  logic         pv_valid = 1'b0;
  logic         pv_ready = 1'b0;
  logic [W-1:0] pv_data = '0;
  logic         exp_err;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      acc_q.delete();
      exp_q.delete();
      lat_q.delete();
      nb = 0;
      pv_valid = 1'b0;
    end else begin
      chk("ser_d_gated", ser_d & ~shift_en, 0);
      if (pv_valid && !pv_ready) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pv_data);
        chk("hold_in_ready", in_ready, out_ready);
        chk("hold_shift_en", shift_en, 0);
      end
      if (shift_en) begin
        sbits = {sbits[W-2:0], ser_d};
        nb++;
        if (nb == W) begin
          nb = 0;
          if (acc_q.size() > 0) chk("serial_word", sbits, acc_q.pop_front());
          else chk("serial_unexpected", 1, 0);
        end
      end
      if (out_valid && !pv_valid) begin
        if (lat_q.size() > 0) chk("latency", cyc - lat_q.pop_front(), W + 2);
        else chk("out_unexpected", 1, 0);
`ifdef SHIFT_SEQ_CHECK_EN
        exp_err = (exp_q.size() > 0) && ((exp_q[0] | force_mask) != exp_q[0]);
`else
        exp_err = 1'b0;
`endif
        chk("err_flag", err, exp_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front() | force_mask);
        else chk("out_unexpected_hs", 1, 0);
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(in_data);
        exp_q.push_back(in_data);
        lat_q.push_back(cyc);
      end
      pv_valid = out_valid;
      pv_ready = out_ready;
      pv_data  = out_data;
    end
  end

  // present a word and hold it until the handshake edge; returns 1 ns after that edge
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    chk("send_timeout", n < 300, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", n < 50, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 300, 1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           stall;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t tbl[6];
  int   base;

  initial begin
    tbl[0] = '{4'hA, 0, 4'hA};
    tbl[1] = '{4'h3, 10, 4'h3};
    tbl[2] = '{4'h0, 0, 4'h0};
    tbl[3] = '{4'hF, 2, 4'hF};
    tbl[4] = '{4'h1, 0, 4'h1};
    tbl[5] = '{4'h8, 5, 4'h8};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; man_ready = 1'b1; rand_mode = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_ser_d", ser_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // table: single words with varying consumer stall
    for (int i = 0; i < 6; i++) begin
      man_ready = (tbl[i].stall == 0);
      send(tbl[i].data);
      wait_valid();
      chk("tbl_out", out_data, tbl[i].exp_out);
      for (int k = 0; k < tbl[i].stall; k++) begin
        @(negedge clk);
        chk("tbl_stall_valid", out_valid, 1);
        chk("tbl_stall_data", out_data, tbl[i].exp_out);
        chk("tbl_stall_in_ready", in_ready, 0);
        chk("tbl_stall_shift", shift_en, 0);
      end
      @(posedge clk);
      #1;
      man_ready = 1'b1;
      wait_idle();
    end

    // back-to-back: second word shifts on the edge after the first handshake
    base = out_cnt;
    send(4'h5);
    send(4'hC);
    @(negedge clk);
    chk("b2b_shift_en", shift_en, 1);
    chk("b2b_ser_d", ser_d, 1);
    wait_idle();
    chk("b2b_count", out_cnt - base, 2);

    // reset in the second shift cycle of 4'hF
    send(4'hF);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_shift_en", shift_en, 0);
    chk("mid_rst_ser_d", ser_d, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(4'h6);
    wait_valid();
    chk("post_rst_word", out_data, 4'h6);
    wait_idle();

    // in_valid toggled while shifting is ignored
    base = out_cnt;
    send(4'h1);
    in_valid = 1'b1; in_data = 4'h9;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1;
    @(negedge clk);
    chk("busy_in_ready", in_ready, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    wait_valid();
    chk("ignore_word", out_data, 4'h1);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("ignore_count", out_cnt - base, 1);
    @(posedge clk);
    #1;

`ifdef SHIFT_SEQ_CHECK_EN
    // readback stuck bit: captured 4'h9 for 4'h8 raises err, next accept clears it
    force_mask = 4'h1;
    send(4'h8);
    wait_valid();
    chk("stuck_out", out_data, 4'h9);
    @(negedge clk);
    chk("stuck_err", err, 1);
    wait_idle();
    force_mask = 4'h0;
    chk("err_held", err, 1);
    send(4'h4);
    chk("err_cleared", err, 0);
    wait_idle();
`endif

    // randomized traffic against the scoreboard
    base = out_cnt;
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(W'($urandom));
    end
    wait_idle();
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rand_count", out_cnt - base, 150);
    chk("rand_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
